// File: rtl/video_pkg.sv
// Shared video types: mode descriptor, power-on default mode and mode-switch FSM states.
package video_pkg;

   localparam int unsigned COORD_W = 12;
   localparam int unsigned MODE_ID_W = 4;

   typedef struct packed {
      logic [MODE_ID_W-1:0] id;
      logic [COORD_W-1:0]   h_total;
      logic [COORD_W-1:0]   v_total;
   } VideoMode;

   localparam VideoMode DEFAULT_MODE = '{id: 4'd0, h_total: 12'd800, v_total: 12'd525};

   typedef enum logic [2:0] {
      IDLE       = 3'd0,
      WAIT_FRAME = 3'd1,
      PLL_REQ    = 3'd2,
      PLL_LOCK   = 3'd3,
      SETTLE     = 3'd4,
      RELEASE    = 3'd5
   } ModeSwitchState;

endpackage

// File: rtl/video_mode_switcher.sv
// Sequences a glitch-free video mode change: frame end, blank, PLL reconfig, lock, settle, release.
// Optional PLL watchdog with fallback to DEFAULT_MODE: define MODE_SWITCH_PLL_TIMEOUT_EN.
module video_mode_switcher
   import video_pkg::*;
#(
   parameter int unsigned SETTLE_CYCLES = 1024,
   parameter int unsigned PLL_TIMEOUT   = 1048576
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               mode_req,
   input  VideoMode           mode_in,
   output logic               mode_ack,
   output logic               busy,
   input  logic [COORD_W-1:0] counterX,
   input  logic [COORD_W-1:0] counterY,
   output VideoMode           videoMode,
   output logic               timing_reset,
   output logic               blank,
   output VideoMode           pll_mode,
   output logic               pll_reconf_req,
   input  logic               pll_reconf_ack,
   input  logic               pll_locked,
   output logic               mode_err
);

   localparam int unsigned SETTLE_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

   // Zero-length waits would make the counters wrap; reject them at elaboration.
   if (SETTLE_CYCLES == 0 || PLL_TIMEOUT == 0) begin : g_bad_param
      $error("video_mode_switcher: SETTLE_CYCLES and PLL_TIMEOUT must be non-zero");
   end

   ModeSwitchState      state, state_nxt;
   logic [SETTLE_W-1:0] settle_cnt, settle_cnt_nxt;
   logic                ack_pending, ack_pending_nxt;
   logic                mode_ack_nxt, busy_nxt, req_nxt;
   logic                blank_nxt, timing_reset_nxt;
   VideoMode            video_mode_nxt, pll_mode_nxt;
   logic                frame_end_c, settle_done_c, timeout_c;

   assign frame_end_c   = (counterX == videoMode.h_total - 12'd1) &&
                          (counterY == videoMode.v_total - 12'd1);
   assign settle_done_c = (settle_cnt == SETTLE_W'(SETTLE_CYCLES - 1));

`ifdef MODE_SWITCH_PLL_TIMEOUT_EN
   localparam int unsigned TO_W = (PLL_TIMEOUT > 1) ? $clog2(PLL_TIMEOUT) : 1;

   logic [TO_W-1:0] to_cnt, to_cnt_nxt;
   logic            mode_err_nxt;

   assign timeout_c = ((state == PLL_REQ) || (state == PLL_LOCK)) &&
                      (to_cnt == TO_W'(PLL_TIMEOUT - 1));

   // Watchdog only runs while waiting on the PLL; restarts on every fallback attempt.
   always_comb begin
      to_cnt_nxt = '0;
      if (((state == PLL_REQ) || (state == PLL_LOCK)) && !timeout_c)
         to_cnt_nxt = to_cnt + TO_W'(1);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         to_cnt   <= '0;
         mode_err <= 1'b0;
      end else begin
         to_cnt   <= to_cnt_nxt;
         mode_err <= mode_err_nxt;
      end
   end
`else
   assign timeout_c = 1'b0;
   assign mode_err  = 1'b0;
`endif

   // State and output registers.
   always_ff @(posedge clock) begin
      if (reset) begin
         state          <= PLL_LOCK;
         settle_cnt     <= '0;
         ack_pending    <= 1'b0;
         mode_ack       <= 1'b0;
         busy           <= 1'b1;
         pll_reconf_req <= 1'b0;
         blank          <= 1'b1;
         timing_reset   <= 1'b1;
         videoMode      <= DEFAULT_MODE;
         pll_mode       <= DEFAULT_MODE;
      end else begin
         state          <= state_nxt;
         settle_cnt     <= settle_cnt_nxt;
         ack_pending    <= ack_pending_nxt;
         mode_ack       <= mode_ack_nxt;
         busy           <= busy_nxt;
         pll_reconf_req <= req_nxt;
         blank          <= blank_nxt;
         timing_reset   <= timing_reset_nxt;
         videoMode      <= video_mode_nxt;
         pll_mode       <= pll_mode_nxt;
      end
   end

   // Next-state logic; lock loss in IDLE takes priority over a pending request.
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE: begin
            if (!pll_locked)
               state_nxt = PLL_LOCK;
            else if (mode_req && (mode_in != videoMode))
               state_nxt = WAIT_FRAME;
         end
         WAIT_FRAME: if (frame_end_c)    state_nxt = PLL_REQ;
         PLL_REQ:    if (pll_reconf_ack) state_nxt = PLL_LOCK;
         PLL_LOCK:   if (pll_locked)     state_nxt = SETTLE;
         SETTLE: begin
            if (!pll_locked)
               state_nxt = PLL_LOCK;
            else if (settle_done_c)
               state_nxt = RELEASE;
         end
         RELEASE:    state_nxt = IDLE;
         default:    state_nxt = IDLE;
      endcase
      if (timeout_c)
         state_nxt = PLL_REQ;
   end

   // Output / datapath next values.
   always_comb begin
      settle_cnt_nxt   = settle_cnt;
      ack_pending_nxt  = ack_pending;
      mode_ack_nxt     = 1'b0;
      blank_nxt        = blank;
      timing_reset_nxt = timing_reset;
      video_mode_nxt   = videoMode;
      pll_mode_nxt     = pll_mode;
`ifdef MODE_SWITCH_PLL_TIMEOUT_EN
      mode_err_nxt     = mode_err;
`endif
      unique case (state)
         IDLE: begin
            if (!pll_locked) begin
               blank_nxt        = 1'b1;
               timing_reset_nxt = 1'b1;
               ack_pending_nxt  = 1'b0;
            end else if (mode_req) begin
               if (mode_in == videoMode) begin
                  mode_ack_nxt = 1'b1;
               end else begin
                  pll_mode_nxt    = mode_in;
                  ack_pending_nxt = 1'b1;
`ifdef MODE_SWITCH_PLL_TIMEOUT_EN
                  mode_err_nxt    = 1'b0;
`endif
               end
            end
         end
         WAIT_FRAME: begin
            if (frame_end_c) begin
               blank_nxt        = 1'b1;
               timing_reset_nxt = 1'b1;
            end
         end
         PLL_LOCK: if (pll_locked) settle_cnt_nxt = '0;
         SETTLE: begin
            if (pll_locked) begin
               if (settle_done_c)
                  video_mode_nxt = pll_mode;
               else
                  settle_cnt_nxt = settle_cnt + SETTLE_W'(1);
            end
         end
         RELEASE: begin
            blank_nxt        = 1'b0;
            timing_reset_nxt = 1'b0;
            mode_ack_nxt     = ack_pending;
            ack_pending_nxt  = 1'b0;
         end
         default: ;
      endcase
      if (timeout_c) begin
         pll_mode_nxt = DEFAULT_MODE;
`ifdef MODE_SWITCH_PLL_TIMEOUT_EN
         mode_err_nxt = 1'b1;
`endif
      end
   end

   assign busy_nxt = (state_nxt != IDLE);
   assign req_nxt  = (state_nxt == PLL_REQ);

endmodule

// File: tb/tb_video_mode_switcher.sv
// Scoreboard bench for video_mode_switcher: expected acks queued by stimulus, popped by a monitor.
module tb_video_mode_switcher;
   import video_pkg::*;

   localparam int unsigned SETTLE = 16;
   localparam int unsigned TIMEOUT = 100;
   localparam int REL_LAT = SETTLE + 2;

   localparam VideoMode MODE_B = '{id: 4'd1, h_total: 12'd1650, v_total: 12'd750};
   localparam VideoMode MODE_C = '{id: 4'd2, h_total: 12'd2200, v_total: 12'd1125};

   logic               clock = 1'b0;
   logic               reset;
   logic               mode_req;
   VideoMode           mode_in;
   logic               mode_ack;
   logic               busy;
   logic [COORD_W-1:0] counterX, counterY;
   VideoMode           videoMode;
   logic               timing_reset;
   logic               blank;
   VideoMode           pll_mode;
   logic               pll_reconf_req;
   logic               pll_reconf_ack;
   logic               pll_locked;
   logic               mode_err;

   int       checks = 0;
   int       errors = 0;
   VideoMode exp_q[$];

   video_mode_switcher #(.SETTLE_CYCLES(SETTLE), .PLL_TIMEOUT(TIMEOUT)) dut (
      .clock          (clock),
      .reset          (reset),
      .mode_req       (mode_req),
      .mode_in        (mode_in),
      .mode_ack       (mode_ack),
      .busy           (busy),
      .counterX       (counterX),
      .counterY       (counterY),
      .videoMode      (videoMode),
      .timing_reset   (timing_reset),
      .blank          (blank),
      .pll_mode       (pll_mode),
      .pll_reconf_req (pll_reconf_req),
      .pll_reconf_ack (pll_reconf_ack),
      .pll_locked     (pll_locked),
      .mode_err       (mode_err)
   );

   always #5 clock = ~clock;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic wait_release(output int n);
      n = 0;
      while (timing_reset && n < 200) begin
         tick();
         n++;
      end
   endtask

   task automatic set_frame_end(input VideoMode m);
      counterX = m.h_total - 12'd1;
      counterY = m.v_total - 12'd1;
   endtask

   // Ack monitor: every mode_ack must match the oldest queued expectation.
   always @(negedge clock) begin
      if (!reset && mode_ack) begin
         checks++;
         if (busy) begin
            errors++;
            $display("FAIL ack_busy_overlap: busy=%0b with mode_ack", busy);
         end
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_ack: videoMode=%0h with no ack expected", videoMode);
         end else begin
            VideoMode e;
            e = exp_q.pop_front();
            checks++;
            if (videoMode !== e) begin
               errors++;
               $display("FAIL ack_mode: got %0h expected %0h", videoMode, e);
            end
         end
      end
   end

   initial begin
      int n;
      reset = 1'b1;
      mode_req = 1'b0;
      mode_in = DEFAULT_MODE;
      counterX = '0;
      counterY = '0;
      pll_reconf_ack = 1'b0;
      pll_locked = 1'b0;

      // Reset values, then power-up lock and settle
      tick();
      tick();
      check("rst_timing_reset", 32'(timing_reset), 32'd1);
      check("rst_blank", 32'(blank), 32'd1);
      check("rst_busy", 32'(busy), 32'd1);
      check("rst_mode_ack", 32'(mode_ack), 32'd0);
      check("rst_pll_req", 32'(pll_reconf_req), 32'd0);
      check("rst_mode_err", 32'(mode_err), 32'd0);
      check("rst_videoMode", 32'(videoMode), 32'(DEFAULT_MODE));
      check("rst_pll_mode", 32'(pll_mode), 32'(DEFAULT_MODE));
      reset = 1'b0;
      repeat (5) tick();
      check("pre_lock_blank", 32'(blank), 32'd1);
      pll_locked = 1'b1;
      wait_release(n);
      check("pwrup_release_latency", 32'(n), 32'(REL_LAT));
      check("pwrup_blank", 32'(blank), 32'd0);
      check("pwrup_busy", 32'(busy), 32'd0);
      check("pwrup_videoMode", 32'(videoMode), 32'(DEFAULT_MODE));

      // Same-mode request: immediate ack, no blanking
      mode_in = DEFAULT_MODE;
      mode_req = 1'b1;
      exp_q.push_back(DEFAULT_MODE);
      tick();
      mode_req = 1'b0;
      check("same_ack", 32'(mode_ack), 32'd1);
      check("same_blank", 32'(blank), 32'd0);
      check("same_timing_reset", 32'(timing_reset), 32'd0);
      tick();
      check("same_ack_pulse", 32'(mode_ack), 32'd0);

      // Mode B requested mid-frame
      counterX = 12'd5;
      counterY = 12'd5;
      mode_in = MODE_B;
      mode_req = 1'b1;
      exp_q.push_back(MODE_B);
      tick();
      mode_req = 1'b0;
      check("b_busy", 32'(busy), 32'd1);
      check("b_pll_mode", 32'(pll_mode), 32'(MODE_B));
      repeat (5) tick();
      check("b_midframe_blank", 32'(blank), 32'd0);
      check("b_midframe_req", 32'(pll_reconf_req), 32'd0);
      set_frame_end(DEFAULT_MODE);
      tick();
      check("b_frame_blank", 32'(blank), 32'd1);
      check("b_frame_timing_reset", 32'(timing_reset), 32'd1);
      check("b_req", 32'(pll_reconf_req), 32'd1);
      counterX = '0;
      counterY = '0;
      repeat (3) tick();
      check("b_req_held", 32'(pll_reconf_req), 32'd1);
      check("b_pll_mode_held", 32'(pll_mode), 32'(MODE_B));
      pll_reconf_ack = 1'b1;
      pll_locked = 1'b0;
      tick();
      pll_reconf_ack = 1'b0;
      check("b_req_drop", 32'(pll_reconf_req), 32'd0);
      repeat (3) tick();
      check("b_mode_unchanged", 32'(videoMode), 32'(DEFAULT_MODE));
      pll_locked = 1'b1;
      wait_release(n);
      check("b_release_latency", 32'(n), 32'(REL_LAT));
      check("b_videoMode", 32'(videoMode), 32'(MODE_B));
      check("b_ack_at_release", 32'(mode_ack), 32'd1);

      // Mode C with lock lost during settle at count 8
      mode_in = MODE_C;
      mode_req = 1'b1;
      exp_q.push_back(MODE_C);
      tick();
      mode_req = 1'b0;
      set_frame_end(MODE_B);
      tick();
      counterX = '0;
      counterY = '0;
      pll_reconf_ack = 1'b1;
      pll_locked = 1'b0;
      tick();
      pll_reconf_ack = 1'b0;
      pll_locked = 1'b1;
      tick();
      repeat (8) tick();
      pll_locked = 1'b0;
      tick();
      check("c_relock_busy", 32'(busy), 32'd1);
      check("c_relock_blank", 32'(blank), 32'd1);
      pll_locked = 1'b1;
      wait_release(n);
      check("c_settle_restart", 32'(n), 32'(REL_LAT));
      check("c_videoMode", 32'(videoMode), 32'(MODE_C));

      // Lock loss while idle: relock without ack, mode kept
      pll_locked = 1'b0;
      tick();
      check("idle_loss_blank", 32'(blank), 32'd1);
      check("idle_loss_timing_reset", 32'(timing_reset), 32'd1);
      check("idle_loss_mode", 32'(videoMode), 32'(MODE_C));
      pll_locked = 1'b1;
      wait_release(n);
      check("idle_relock_latency", 32'(n), 32'(REL_LAT));
      check("idle_relock_mode", 32'(videoMode), 32'(MODE_C));

      // Reset asserted while in PLL_REQ
      mode_in = MODE_B;
      mode_req = 1'b1;
      tick();
      mode_req = 1'b0;
      set_frame_end(MODE_C);
      tick();
      counterX = '0;
      counterY = '0;
      check("r_req_before", 32'(pll_reconf_req), 32'd1);
      reset = 1'b1;
      tick();
      check("r_req_drop", 32'(pll_reconf_req), 32'd0);
      check("r_videoMode", 32'(videoMode), 32'(DEFAULT_MODE));
      check("r_pll_mode", 32'(pll_mode), 32'(DEFAULT_MODE));
      check("r_blank", 32'(blank), 32'd1);
      check("r_busy", 32'(busy), 32'd1);
      reset = 1'b0;
      wait_release(n);
      check("r_release_latency", 32'(n), 32'(REL_LAT));

`ifdef MODE_SWITCH_PLL_TIMEOUT_EN
      // PLL never acks: fall back to the default mode
      mode_in = MODE_B;
      mode_req = 1'b1;
      exp_q.push_back(DEFAULT_MODE);
      tick();
      mode_req = 1'b0;
      set_frame_end(DEFAULT_MODE);
      tick();
      counterX = '0;
      counterY = '0;
      n = 0;
      while (!mode_err && n < 300) begin
         tick();
         n++;
      end
      check("to_cycles", 32'(n), 32'(TIMEOUT));
      check("to_pll_mode", 32'(pll_mode), 32'(DEFAULT_MODE));
      check("to_req", 32'(pll_reconf_req), 32'd1);
      pll_reconf_ack = 1'b1;
      pll_locked = 1'b0;
      tick();
      pll_reconf_ack = 1'b0;
      pll_locked = 1'b1;
      wait_release(n);
      check("to_release_latency", 32'(n), 32'(REL_LAT));
      check("to_videoMode", 32'(videoMode), 32'(DEFAULT_MODE));
      check("to_mode_err_sticky", 32'(mode_err), 32'd1);
`endif

      repeat (3) tick();
      check("acks_all_seen", 32'(exp_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
